// File: rtl/spi_xfer_pkg.sv
// Shared types and sizing helpers for the SPI transaction controller.
package spi_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_SEND,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } xfer_state_e;

    function automatic int nbw(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    function automatic int cnt_width(input int setup_clks, input int hold_clks,
                                     input int idle_clks, input int tout_clks);
        int m;
        m = setup_clks;
        if (hold_clks > m) m = hold_clks;
        if (idle_clks > m) m = idle_clks;
        if (tout_clks > m) m = tout_clks;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Client + byte-engine signal bundle; master = controller side, slave = client/engine side.
interface spi_xfer_ctrl_if #(
    parameter int MAX_BYTES = 4
);
    import spi_xfer_pkg::*;

    localparam int NBW = nbw(MAX_BYTES);

    logic           i_Start;
    logic [NBW-1:0] i_Num_Bytes;
    logic           o_TX_Req;
    logic [7:0]     i_TX_Byte;
    logic           i_TX_Byte_DV;
    logic           o_RX_DV;
    logic [7:0]     o_RX_Byte;
    logic [NBW-1:0] o_RX_Index;
    logic           o_Busy;
    logic           o_Done;
    logic           o_Abort;
    logic           o_Eng_TX_DV;
    logic [7:0]     o_Eng_TX_Byte;
    logic           i_Eng_TX_Ready;
    logic           i_Eng_RX_DV;
    logic [7:0]     i_Eng_RX_Byte;
    logic           o_SPI_CS_n;

    modport master (
        input  i_Start, i_Num_Bytes, i_TX_Byte, i_TX_Byte_DV,
               i_Eng_TX_Ready, i_Eng_RX_DV, i_Eng_RX_Byte,
        output o_TX_Req, o_RX_DV, o_RX_Byte, o_RX_Index, o_Busy, o_Done, o_Abort,
               o_Eng_TX_DV, o_Eng_TX_Byte, o_SPI_CS_n
    );

    modport slave (
        output i_Start, i_Num_Bytes, i_TX_Byte, i_TX_Byte_DV,
               i_Eng_TX_Ready, i_Eng_RX_DV, i_Eng_RX_Byte,
        input  o_TX_Req, o_RX_DV, o_RX_Byte, o_RX_Index, o_Busy, o_Done, o_Abort,
               o_Eng_TX_DV, o_Eng_TX_Byte, o_SPI_CS_n
    );

endinterface

// File: rtl/spi_cs_timer.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
module spi_cs_timer #(
    parameter int W = 4
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte CS-framed SPI transaction controller feeding a byte-level SPI engine.
// Optional client watchdog: define SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter int MAX_BYTES     = 4,
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2,
    parameter int CS_IDLE_CLKS  = 2,
    parameter int TIMEOUT_CLKS  = 1024
) (
    input  logic            i_Clk,
    input  logic            i_Rst_L,
    spi_xfer_ctrl_if.master bus
);

    localparam int NBW = nbw(MAX_BYTES);
    localparam int CW  = cnt_width(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS, TIMEOUT_CLKS);

    xfer_state_e    state_q, state_d;
    logic           cs_n_q, cs_n_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tx_req_q, tx_req_d;
    logic           rx_dv_q, rx_dv_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic [NBW-1:0] rx_idx_q, rx_idx_d;
    logic           eng_dv_q, eng_dv_d;
    logic [7:0]     eng_byte_q, eng_byte_d;
    logic [NBW-1:0] num_q, num_d;
    logic [NBW-1:0] cnt_q, cnt_d;
    logic           seen_q, seen_d;
    logic           rx_prev_q;
    logic           rx_edge;
    logic [NBW-1:0] n_clamp;
    logic           tmr_load;
    logic [CW-1:0]  tmr_val;
    logic           tmr_done;
`ifdef SPI_XFER_TIMEOUT_EN
    logic           abort_q, abort_d;
    logic           aborted_q, aborted_d;
`endif

    // Timer is loaded with N-1 so that the state is occupied exactly N cycles.
    spi_cs_timer #(.W(CW)) u_timer (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_req_d   = 1'b0;
        rx_dv_d    = 1'b0;
        rx_byte_d  = rx_byte_q;
        rx_idx_d   = rx_idx_q;
        eng_dv_d   = 1'b0;
        eng_byte_d = eng_byte_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef SPI_XFER_TIMEOUT_EN
        abort_d    = 1'b0;
        aborted_d  = aborted_q;
`endif
        rx_edge = bus.i_Eng_RX_DV & ~rx_prev_q;
        n_clamp = (bus.i_Num_Bytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : bus.i_Num_Bytes;

        case (state_q)
            ST_IDLE: if (bus.i_Start) begin
                if (n_clamp == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d  = ST_SETUP;
                    cs_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    num_d    = n_clamp;
                    cnt_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(CS_SETUP_CLKS - 1);
`ifdef SPI_XFER_TIMEOUT_EN
                    aborted_d = 1'b0;
`endif
                end
            end
            ST_SETUP: if (tmr_done) begin
                state_d  = ST_REQ;
                tx_req_d = 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = CW'(TIMEOUT_CLKS - 1);
`endif
            end
            ST_REQ: begin
                if (bus.i_TX_Byte_DV) begin
                    eng_byte_d = bus.i_TX_Byte;
                    state_d    = ST_SEND;
                end
`ifdef SPI_XFER_TIMEOUT_EN
                else if (tmr_done) begin
                    abort_d   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = CW'(CS_HOLD_CLKS - 1);
                end
`endif
            end
            ST_SEND: if (bus.i_Eng_TX_Ready) begin
                eng_dv_d = 1'b1;
                seen_d   = 1'b0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (rx_edge) begin
                    rx_dv_d   = 1'b1;
                    rx_byte_d = bus.i_Eng_RX_Byte;
                    rx_idx_d  = cnt_q;
                    seen_d    = 1'b1;
                end
                if ((seen_q || rx_edge) && bus.i_Eng_TX_Ready) begin
                    tmr_load = 1'b1;
                    if (cnt_q == num_q - NBW'(1)) begin
                        state_d = ST_HOLD;
                        tmr_val = CW'(CS_HOLD_CLKS - 1);
                    end else begin
                        cnt_d    = cnt_q + NBW'(1);
                        state_d  = ST_REQ;
                        tx_req_d = 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
                        tmr_val  = CW'(TIMEOUT_CLKS - 1);
`endif
                    end
                end
            end
            ST_HOLD: if (tmr_done) begin
                cs_n_d   = 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
                done_d   = ~aborted_q;
`else
                done_d   = 1'b1;
`endif
                state_d  = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = CW'(CS_IDLE_CLKS - 1);
            end
            ST_GAP: if (tmr_done) begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_req_q   <= 1'b0;
            rx_dv_q    <= 1'b0;
            rx_byte_q  <= '0;
            rx_idx_q   <= '0;
            eng_dv_q   <= 1'b0;
            eng_byte_q <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            rx_prev_q  <= 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
            abort_q    <= 1'b0;
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_req_q   <= tx_req_d;
            rx_dv_q    <= rx_dv_d;
            rx_byte_q  <= rx_byte_d;
            rx_idx_q   <= rx_idx_d;
            eng_dv_q   <= eng_dv_d;
            eng_byte_q <= eng_byte_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            rx_prev_q  <= bus.i_Eng_RX_DV;
`ifdef SPI_XFER_TIMEOUT_EN
            abort_q    <= abort_d;
            aborted_q  <= aborted_d;
`endif
        end
    end

    assign bus.o_SPI_CS_n    = cs_n_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Done        = done_q;
    assign bus.o_TX_Req      = tx_req_q;
    assign bus.o_RX_DV       = rx_dv_q;
    assign bus.o_RX_Byte     = rx_byte_q;
    assign bus.o_RX_Index    = rx_idx_q;
    assign bus.o_Eng_TX_DV   = eng_dv_q;
    assign bus.o_Eng_TX_Byte = eng_byte_q;
`ifdef SPI_XFER_TIMEOUT_EN
    assign bus.o_Abort       = abort_q;
`else
    assign bus.o_Abort       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural byte engine looping TX back to RX.
module tb_spi_xfer_ctrl;
    import spi_xfer_pkg::*;

    localparam int MAX_BYTES = 4;
`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TOUT = 16;
`else
    localparam int TOUT = 1024;
`endif

    logic i_Clk   = 1'b0;
    logic i_Rst_L = 1'b0;

    spi_xfer_ctrl_if #(.MAX_BYTES(MAX_BYTES)) bus ();

    spi_xfer_ctrl #(
        .MAX_BYTES     (MAX_BYTES),
        .CS_SETUP_CLKS (2),
        .CS_HOLD_CLKS  (2),
        .CS_IDLE_CLKS  (2),
        .TIMEOUT_CLKS  (TOUT)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .bus     (bus)
    );

    always #5 i_Clk = ~i_Clk;

    // Engine: ready drops after DV, byte-done level rises mid-byte and falls as ready returns.
    logic [3:0] eng_ctr;
    logic [7:0] eng_lat;
    always @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bus.i_Eng_TX_Ready <= 1'b1;
            bus.i_Eng_RX_DV    <= 1'b0;
            bus.i_Eng_RX_Byte  <= 8'h00;
            eng_ctr            <= 4'd0;
            eng_lat            <= 8'h00;
        end else if (bus.i_Eng_TX_Ready) begin
            if (bus.o_Eng_TX_DV) begin
                bus.i_Eng_TX_Ready <= 1'b0;
                eng_lat            <= bus.o_Eng_TX_Byte;
                eng_ctr            <= 4'd6;
            end
        end else begin
            eng_ctr <= eng_ctr - 4'd1;
            if (eng_ctr == 4'd3) begin
                bus.i_Eng_RX_DV   <= 1'b1;
                bus.i_Eng_RX_Byte <= eng_lat;
            end
            if (eng_ctr == 4'd1) begin
                bus.i_Eng_TX_Ready <= 1'b1;
                bus.i_Eng_RX_DV    <= 1'b0;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] tx_q [4];
    logic [7:0] rx_b [8];
    int         rx_i [8];
    int n_req, n_rx, n_done, n_abort, n_fall, n_rise, n_dv_cs_hi, tot_abort;
    int req_lat, done_cyc, rise_cyc, busy_lo, first_low, abort_cyc;
    bit saw_busy, ended_ok;

    // One transaction: client answers each o_TX_Req one cycle later; optional mid-frame
    // restart pulse and optional async reset while the given byte is in flight.
    task automatic xfer(input int n, input bit restart, input int rst_req, input bit supply);
        int  cyc, rst_wait;
        bit  fin, cs_prev;
        n_req = 0; n_rx = 0; n_done = 0; n_abort = 0; n_fall = 0; n_rise = 0; n_dv_cs_hi = 0;
        req_lat = -1; done_cyc = -1; rise_cyc = -1; busy_lo = -1; first_low = -1; abort_cyc = -1;
        saw_busy = 0; ended_ok = 0; rst_wait = -1; fin = 0; cyc = 0;
        cs_prev = bus.o_SPI_CS_n;
        bus.i_Num_Bytes = 3'(n);
        bus.i_Start     = 1'b1;
        while (!fin) begin
            @(negedge i_Clk);
            cyc++;
            bus.i_Start      = 1'b0;
            bus.i_TX_Byte_DV = 1'b0;
            if (bus.o_TX_Req) begin
                n_req++;
                if (n_req == 1) req_lat = cyc;
                if (supply) begin
                    bus.i_TX_Byte    = tx_q[(n_req > 4) ? 3 : n_req - 1];
                    bus.i_TX_Byte_DV = 1'b1;
                end
                if (restart && n_req == 2) begin
                    bus.i_Num_Bytes = 3'd1;
                    bus.i_Start     = 1'b1;
                end
                if (rst_req != 0 && n_req == rst_req) rst_wait = 4;
            end
            if (bus.o_RX_DV && n_rx < 8) begin
                rx_b[n_rx] = bus.o_RX_Byte;
                rx_i[n_rx] = int'(bus.o_RX_Index);
                n_rx++;
            end
            if (bus.o_Done) begin n_done++; done_cyc = cyc; end
            if (bus.o_Abort) begin n_abort++; abort_cyc = cyc; end
            if (bus.o_Eng_TX_DV && bus.o_SPI_CS_n) n_dv_cs_hi++;
            if (cs_prev && !bus.o_SPI_CS_n) begin n_fall++; if (first_low < 0) first_low = cyc; end
            if (!cs_prev && bus.o_SPI_CS_n) begin n_rise++; rise_cyc = cyc; end
            cs_prev = bus.o_SPI_CS_n;
            if (bus.o_Busy) saw_busy = 1;
            if ((n_done > 0 || n_abort > 0) && !bus.o_Busy) begin
                busy_lo = cyc; fin = 1; ended_ok = 1;
            end
            if (rst_wait == 0) begin
                #2 i_Rst_L = 1'b0;
                #1;
                chk("rst_cs_n", bus.o_SPI_CS_n, 1);
                chk("rst_busy", bus.o_Busy, 0);
                chk("rst_eng_dv_byte", {bus.o_Eng_TX_DV, bus.o_Eng_TX_Byte}, 0);
                chk("rst_rx", {bus.o_RX_DV, bus.o_RX_Byte, 5'(bus.o_RX_Index)}, 0);
                chk("rst_req_done", {bus.o_TX_Req, bus.o_Done, bus.o_Abort}, 0);
                fin = 1; ended_ok = 1;
            end else if (rst_wait > 0) begin
                rst_wait--;
            end
            if (cyc >= 600) fin = 1;
        end
        chk("xfer_ended", ended_ok, 1);
        tot_abort += n_abort;
    endtask

    initial begin
        tot_abort = 0;
        bus.i_Start      = 1'b0;
        bus.i_Num_Bytes  = '0;
        bus.i_TX_Byte    = 8'h00;
        bus.i_TX_Byte_DV = 1'b0;
        repeat (2) @(negedge i_Clk);
        chk("reset_cs_n", bus.o_SPI_CS_n, 1);
        chk("reset_outs", {bus.o_Busy, bus.o_Done, bus.o_TX_Req, bus.o_RX_DV, bus.o_Eng_TX_DV}, 0);
        i_Rst_L = 1'b1;
        repeat (2) @(negedge i_Clk);

        // Single byte
        tx_q[0] = 8'hA5;
        xfer(1, 0, 0, 1);
        chk("n1_req_lat", req_lat, 3);
        chk("n1_cs_fall_cyc", first_low, 1);
        chk("n1_rx_n", n_rx, 1);
        chk("n1_rx0", rx_b[0], 8'hA5);
        chk("n1_idx0", rx_i[0], 0);
        chk("n1_done_n", n_done, 1);
        chk("n1_done_at_cs_rise", rise_cyc, done_cyc);
        chk("n1_busy_gap", busy_lo - done_cyc, 2);
        chk("n1_frames", n_fall, 1);
        chk("n1_dv_cs_hi", n_dv_cs_hi, 0);
        repeat (2) @(negedge i_Clk);

        // Three bytes in one frame
        tx_q[0] = 8'h01; tx_q[1] = 8'h80; tx_q[2] = 8'hFF;
        xfer(3, 0, 0, 1);
        chk("n3_rx_n", n_rx, 3);
        chk("n3_rx0", rx_b[0], 8'h01);
        chk("n3_rx1", rx_b[1], 8'h80);
        chk("n3_rx2", rx_b[2], 8'hFF);
        chk("n3_idx", {rx_i[0][3:0], rx_i[1][3:0], rx_i[2][3:0]}, 12'h012);
        chk("n3_frames", {n_fall[3:0], n_rise[3:0]}, 8'h11);
        chk("n3_done_n", n_done, 1);
        repeat (2) @(negedge i_Clk);

        // Zero length
        xfer(0, 0, 0, 1);
        chk("n0_done_cyc", done_cyc, 1);
        chk("n0_cs_falls", n_fall, 0);
        chk("n0_busy_seen", saw_busy, 0);
        chk("n0_req_n", n_req, 0);
        repeat (2) @(negedge i_Clk);

        // Clamp to MAX_BYTES, with a restart pulse mid-frame
        tx_q[0] = 8'h11; tx_q[1] = 8'h22; tx_q[2] = 8'h33; tx_q[3] = 8'h44;
        xfer(7, 1, 0, 1);
        chk("n7_req_n", n_req, 4);
        chk("n7_rx_n", n_rx, 4);
        chk("n7_rx3", rx_b[3], 8'h44);
        chk("n7_idx3", rx_i[3], 3);
        chk("n7_done_n", n_done, 1);
        chk("n7_frames", n_fall, 1);
        repeat (4) @(negedge i_Clk);
        chk("n7_no_restart", bus.o_Busy, 0);

        // Async reset during byte 2
        tx_q[0] = 8'h5A; tx_q[1] = 8'h3C; tx_q[2] = 8'h99;
        xfer(3, 0, 2, 1);
        chk("rst_rx_before", n_rx, 1);
        chk("rst_no_done", n_done, 0);
        @(negedge i_Clk);
        chk("rst_no_done_after", bus.o_Done, 0);
        i_Rst_L = 1'b1;
        repeat (2) @(negedge i_Clk);

        tx_q[0] = 8'hC3;
        xfer(1, 0, 0, 1);
        chk("post_rst_rx0", rx_b[0], 8'hC3);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_req_lat", req_lat, 3);
        repeat (2) @(negedge i_Clk);

`ifdef SPI_XFER_TIMEOUT_EN
        xfer(2, 0, 0, 0);
        chk("to_abort_n", n_abort, 1);
        chk("to_abort_cyc", abort_cyc - req_lat, TOUT);
        chk("to_cs_rise", rise_cyc - abort_cyc, 2);
        chk("to_no_done", n_done, 0);
        chk("to_rx_n", n_rx, 0);
`else
        chk("abort_tied_low", tot_abort, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
